cla_sub16_seq: RTL

- Sequential inverse of the 16-bit CLA adder. Takes an adder result ({carry_out, sum}), the operand b and carry_in, and recovers operand a = {carry_out,sum} - b - carry_in.
- Works one 4-bit slice per cycle with a valid/ready handshake on both sides.
- Sits beside cla_adder16 in self-checking benches and in the datapath as the adder-result decoder. A recovered a that mismatches the applied a flags an adder fault.

---
 rtl/cla_sub16_seq_pkg.sv | 15 +
 rtl/cla_sub16_seq_if.sv | 40 ++++
 rtl/cla_sub16_seq_slice.sv | 42 ++++
 rtl/cla_sub16_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cla_sub16_seq_pkg.sv
// cla_sub16_seq_pkg: shared constants and FSM state type for the sequential
// CLA subtractor (adder-result decoder).
package cla_sub16_seq_pkg;

   localparam int unsigned CLA_WIDTH = 16;
   localparam int unsigned CLA_SLICE = 4;
   localparam int unsigned ERRCNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cla_sub16_seq_if.sv
// cla_sub16_seq_if: request/result handshake bundle for cla_sub16_seq.
// Optional CLA_SUB_ERRCNT_EN adds the saturating err_count output.
interface cla_sub16_seq_if
   import cla_sub16_seq_pkg::*;
#(
   parameter int unsigned WIDTH = CLA_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] a_out;
   logic             err;
`ifdef CLA_SUB_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_count;
`endif

   // Requester / consumer side
   modport master (
      output in_valid, sum, carry_out, b, carry_in, out_ready,
      input  in_ready, out_valid, a_out, err
`ifdef CLA_SUB_ERRCNT_EN
      , input err_count
`endif
   );

   // Decoder side
   modport slave (
      input  in_valid, sum, carry_out, b, carry_in, out_ready,
      output in_ready, out_valid, a_out, err
`ifdef CLA_SUB_ERRCNT_EN
      , output err_count
`endif
   );

endinterface

// File: rtl/cla_sub16_seq_slice.sv
// cla_sub_slice: combinational SLICE-bit lookahead computing x + ~b + cin.
// Each carry is formed as a sum of generate terms gated by the downstream
// propagates, not as a ripple chain.
module cla_sub_slice #(
   parameter int unsigned SLICE = 4
) (
   input  logic [SLICE-1:0] x_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             cin_i,
   output logic [SLICE-1:0] r_o,
   output logic             cout_o
);
   logic [SLICE-1:0] g;
   logic [SLICE-1:0] p;
   logic [SLICE:0]   c;

   assign g = x_i & ~b_i;
   assign p = x_i ^ ~b_i;

   // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (cin & p[0..i])
   always_comb begin
      logic cc;
      logic pp;
      c    = '0;
      c[0] = cin_i;
      for (int unsigned i = 0; i < SLICE; i++) begin
         cc = 1'b0;
         for (int unsigned j = 0; j <= i; j++) begin
            pp = 1'b1;
            for (int unsigned m = j + 1; m <= i; m++) pp = pp & p[m];
            cc = cc | (g[j] & pp);
         end
         pp = 1'b1;
         for (int unsigned m = 0; m <= i; m++) pp = pp & p[m];
         c[i+1] = cc | (cin_i & pp);
      end
   end

   assign r_o    = p ^ c[SLICE-1:0];
   assign cout_o = c[SLICE];

endmodule

// File: rtl/cla_sub16_seq.sv
// cla_sub16_seq: recovers a = {carry_out,sum} - b - carry_in one slice per
// cycle using a single time-multiplexed cla_sub_slice. err flags results
// outside 0..2^WIDTH-1. Define CLA_SUB_ERRCNT_EN for the err_count output.
module cla_sub16_seq
   import cla_sub16_seq_pkg::*;
#(
   parameter int unsigned WIDTH = CLA_WIDTH,
   parameter int unsigned SLICE = CLA_SLICE
) (
   input logic           clk,
   input logic           rst_n,
   cla_sub16_seq_if.slave bus
);
   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             co_q, co_d;
   logic             c_q, c_d;
   logic             err_q, err_d;
   logic [KW-1:0]    k_q, k_d;
   logic             in_ready_c, out_valid_c;

   logic [SLICE-1:0] x_sl, b_sl, r_sl;
   logic             cout_sl;

   assign x_sl = x_q[k_q*SLICE +: SLICE];
   assign b_sl = b_q[k_q*SLICE +: SLICE];

   cla_sub_slice #(.SLICE(SLICE)) u_slice (
      .x_i   (x_sl),
      .b_i   (b_sl),
      .cin_i (c_q),
      .r_o   (r_sl),
      .cout_o(cout_sl)
   );

   // Next-state, datapath updates and handshake outputs
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      b_d         = b_q;
      a_d         = a_q;
      co_d        = co_q;
      c_d         = c_q;
      err_d       = err_q;
      k_d         = k_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               x_d     = bus.sum;
               co_d    = bus.carry_out;
               b_d     = bus.b;
               c_d     = ~bus.carry_in;
               k_d     = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            a_d[k_q*SLICE +: SLICE] = r_sl;
            c_d = cout_sl;
            k_d = k_q + 1'b1;
            if (k_q == KW'(NSLICE - 1)) begin
               // Top bit: carry_out + ~0 + final carry; bit WIDTH of the sum
               err_d   = ~(co_q ^ cout_sl);
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Operand, borrow-chain and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q   <= '0;
         b_q   <= '0;
         a_q   <= '0;
         co_q  <= 1'b0;
         c_q   <= 1'b0;
         err_q <= 1'b0;
         k_q   <= '0;
      end else begin
         x_q   <= x_d;
         b_q   <= b_d;
         a_q   <= a_d;
         co_q  <= co_d;
         c_q   <= c_d;
         err_q <= err_d;
         k_q   <= k_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.a_out     = a_q;
   assign bus.err       = err_q;

`ifdef CLA_SUB_ERRCNT_EN
   logic [ERRCNT_W-1:0] cnt_q, cnt_d;

   // Count erroneous results as they are handed off, saturating at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == DONE && bus.out_ready && err_q && cnt_q != '1)
         cnt_d = cnt_q + 1'b1;
   end

   // Error counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign bus.err_count = cnt_q;
`endif

endmodule
